// File: rtl/niosii_pio_pkg.sv
// rtl/niosii_pio_pkg.sv - shared constants for the Nios II button PIO
package niosii_pio_pkg;

    // Word addresses of the slave registers; address 1 is reserved and reads 0
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Which debounced transition sets an edge-capture bit
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/niosii_button_pio_if.sv
// rtl/niosii_button_pio_if.sv - Avalon-MM slave bus and irq bundle for the button PIO
interface niosii_button_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/button_debounce_bit.sv
// rtl/button_debounce_bit.sv - two-flop synchroniser and stable-count debouncer for one pin
module button_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_in,
    output logic deb_out
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Synchroniser chain: next-state is a plain shift of the raw pin
    always_comb begin
        sync1_d = pin_in;
        sync2_d = sync1_q;
    end

    // Synchroniser flops, reset to the idle level so nothing moves after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign deb_out = sync2_q;
    end else begin : g_count
        localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             deb_q, deb_d;

        // Count consecutive cycles where the synchronised input disagrees with
        // the debounced value; any agreement restarts the count
        always_comb begin
            cnt_d = cnt_q;
            deb_d = deb_q;
            if (sync2_q == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Counter and debounced state
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                deb_q <= RESET_VAL;
            end else begin
                cnt_q <= cnt_d;
                deb_q <= deb_d;
            end
        end

        assign deb_out = deb_q;
    end

endmodule

// File: rtl/niosii_button_pio.sv
// rtl/niosii_button_pio.sv - debounced input PIO with edge capture and maskable irq
module niosii_button_pio
    import niosii_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 2,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  in_port,
    niosii_button_pio_if.slave bus
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] rise, fall, edge_evt, clr;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        button_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_LEVEL[i])
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .pin_in  (in_port[i]),
            .deb_out (deb[i])
        );
    end

    // Edge detect, register writes and read mux next-state
    always_comb begin
        deb_dly_d = deb;
        rise      = deb & ~deb_dly_q;
        fall      = ~deb & deb_dly_q;
        case (EDGE_TYPE)
            EDGE_RISE: edge_evt = rise;
            EDGE_FALL: edge_evt = fall;
            default:   edge_evt = rise | fall;
        endcase

        wr_en = bus.chipselect & ~bus.write_n;
        clr   = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

        // A new edge in the same cycle as its clear keeps the bit set
        edgecap_d = (edgecap_q & ~clr) | edge_evt;

        irqmask_d = irqmask_q;
        if (wr_en && bus.address == ADDR_IRQMASK) begin
            irqmask_d = bus.writedata[WIDTH-1:0];
        end

        // Read data is refreshed every cycle regardless of chipselect
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = deb;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    // Register state; deb_dly resets to the idle level so reset creates no edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_dly_q  <= RESET_LEVEL;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
        end else begin
            deb_dly_q  <= deb_dly_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edgecap_q & irqmask_q);
    assign unused_wdata = ^bus.writedata;

endmodule

// File: tb/tb_niosii_button_pio.sv
// tb/tb_niosii_button_pio.sv - self-checking bench with a behavioural model for two PIO configurations
module tb_niosii_button_pio;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] in_a, in_b;
    int         total = 0;
    int         bad = 0;
    bit         check_en = 1'b0;

    always #5 clk = ~clk;

    niosii_button_pio_if bus_a ();
    niosii_button_pio_if bus_b ();

    niosii_button_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(2), .RESET_LEVEL(4'h0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .in_port(in_a), .bus(bus_a)
    );

    niosii_button_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(1), .RESET_LEVEL(4'hF)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .in_port(in_b), .bus(bus_b)
    );

    // Behavioural model, index 0 = config A, 1 = config B.
    // m_h[n][0] is the last pin sample, m_h[n][k] the synchronised value k-1 cycles ago.
    logic [3:0]  m_lvl [2];
    int          m_et  [2];
    logic [3:0]  m_h   [2][DEB+1];
    logic [3:0]  m_deb [2];
    logic [3:0]  m_debq[2];
    logic [3:0]  m_cap [2];
    logic [3:0]  m_mask[2];
    logic [31:0] m_rd  [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int n);
        for (int k = 0; k <= DEB; k++) m_h[n][k] = m_lvl[n];
        m_deb[n]  = m_lvl[n];
        m_debq[n] = m_lvl[n];
        m_cap[n]  = '0;
        m_mask[n] = '0;
        m_rd[n]   = '0;
    endtask

    task automatic model_step(input int n, input logic [3:0] pin, input logic [1:0] a,
                              input logic cs, input logic wn, input logic [31:0] wd);
        logic [3:0] flips, evt, clr, rise, fall;
        // A bit flips once its synchronised value has disagreed for DEB straight cycles
        flips = 4'hF;
        for (int k = 1; k <= DEB; k++) flips &= m_h[n][k] ^ m_deb[n];
        rise = m_deb[n] & ~m_debq[n];
        fall = ~m_deb[n] & m_debq[n];
        evt  = (m_et[n] == 0) ? rise : (m_et[n] == 1) ? fall : (rise | fall);
        case (a)
            2'd0:    m_rd[n] = {28'd0, m_deb[n]};
            2'd2:    m_rd[n] = {28'd0, m_mask[n]};
            2'd3:    m_rd[n] = {28'd0, m_cap[n]};
            default: m_rd[n] = 32'd0;
        endcase
        clr = (cs && !wn && a == 2'd3) ? wd[3:0] : 4'h0;
        m_cap[n] = (m_cap[n] & ~clr) | evt;
        if (cs && !wn && a == 2'd2) m_mask[n] = wd[3:0];
        m_debq[n] = m_deb[n];
        m_deb[n]  = m_deb[n] ^ flips;
        for (int k = DEB; k >= 1; k--) m_h[n][k] = m_h[n][k-1];
        m_h[n][0] = pin;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, in_a, bus_a.address, bus_a.chipselect, bus_a.write_n, bus_a.writedata);
            model_step(1, in_b, bus_b.address, bus_b.chipselect, bus_b.write_n, bus_b.writedata);
        end
    end

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_rd_a", bus_a.readdata, m_rd[0]);
            chk("cyc_irq_a", bus_a.irq, |(m_cap[0] & m_mask[0]));
            chk("cyc_rd_b", bus_b.readdata, m_rd[1]);
            chk("cyc_irq_b", bus_b.irq, |(m_cap[1] & m_mask[1]));
        end
    end

    task automatic set_bus(input int n, input logic [1:0] a, input logic cs,
                           input logic wn, input logic [31:0] d);
        if (n == 0) begin
            bus_a.address = a; bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.writedata = d;
        end else begin
            bus_b.address = a; bus_b.chipselect = cs; bus_b.write_n = wn; bus_b.writedata = d;
        end
    endtask

    task automatic wr(input int n, input logic [1:0] a, input logic [31:0] d);
        set_bus(n, a, 1'b1, 1'b0, d);
        @(negedge clk);
        set_bus(n, a, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic rd(input int n, input logic [1:0] a, input string nm, input logic [31:0] exp);
        set_bus(n, a, 1'b0, 1'b1, 32'd0);
        @(negedge clk);
        chk(nm, (n == 0) ? bus_a.readdata : bus_b.readdata, exp);
    endtask

    initial begin
        m_lvl[0] = 4'h0; m_lvl[1] = 4'hF;
        m_et[0]  = 2;    m_et[1]  = 1;
        in_a = 4'h0;
        in_b = 4'hF;
        set_bus(0, 2'd0, 1'b0, 1'b1, 32'd0);
        set_bus(1, 2'd0, 1'b0, 1'b1, 32'd0);
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        check_en = 1'b1;

        // Reset state
        rd(0, 2'd0, "rst_data_a", 32'h0);
        chk("rst_irq_a", bus_a.irq, 1'b0);
        rd(0, 2'd3, "rst_cap_a", 32'h0);
        rd(1, 2'd0, "rst_data_b", 32'hF);
        rd(1, 2'd3, "rst_cap_b", 32'h0);

        // Bit 1 press: deb changes on the 6th edge, visible in readdata on the 7th
        set_bus(0, 2'd0, 1'b0, 1'b1, 32'd0);
        in_a = 4'h2;
        repeat (6) @(negedge clk);
        chk("lat_before", bus_a.readdata, 32'h0);
        @(negedge clk);
        chk("lat_data", bus_a.readdata, 32'h2);
        rd(0, 2'd3, "press_cap", 32'h2);
        chk("press_irq", bus_a.irq, 1'b0);

        // 3-cycle glitch is rejected, 4-cycle pulse is accepted
        in_a = 4'h3;
        repeat (3) @(negedge clk);
        in_a = 4'h2;
        repeat (12) @(negedge clk);
        rd(0, 2'd0, "glitch_data", 32'h2);
        rd(0, 2'd3, "glitch_cap", 32'h2);
        in_a = 4'h3;
        repeat (4) @(negedge clk);
        in_a = 4'h2;
        repeat (12) @(negedge clk);
        rd(0, 2'd3, "pulse4_cap", 32'h3);

        // Mask enables irq next cycle; W1C drops it next cycle
        wr(0, 2'd2, 32'h2);
        chk("mask_irq", bus_a.irq, 1'b1);
        wr(0, 2'd3, 32'h2);
        chk("w1c_irq", bus_a.irq, 1'b0);
        rd(0, 2'd3, "w1c_cap", 32'h1);
        wr(0, 2'd3, 32'h1);
        rd(0, 2'd3, "clr_cap", 32'h0);

        // Clear of bit 2 lands on the same edge that captures bit 2
        in_a = 4'h6;
        repeat (6) @(negedge clk);
        wr(0, 2'd3, 32'h4);
        rd(0, 2'd3, "coinc_cap", 32'h4);
        wr(0, 2'd3, 32'h1);
        rd(0, 2'd3, "keep_bit2", 32'h4);
        chk("model_cap_a", {28'd0, m_cap[0]}, 32'h4);

        // Active-low config, falling edges only
        in_b = 4'h7;
        repeat (12) @(negedge clk);
        rd(1, 2'd3, "b_press_cap", 32'h8);
        in_b = 4'hF;
        repeat (12) @(negedge clk);
        rd(1, 2'd3, "b_release_cap", 32'h8);
        rd(1, 2'd0, "b_data", 32'hF);
        wr(1, 2'd2, 32'h8);
        chk("b_irq", bus_b.irq, 1'b1);
        chk("model_cap_b", {28'd0, m_cap[1]}, 32'h8);

        // Randomised traffic with an asynchronous reset mid-run
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) in_a = in_a ^ (4'h1 << $urandom_range(3));
            if ($urandom_range(7) == 0) in_b = in_b ^ (4'h1 << $urandom_range(3));
            set_bus(0, 2'($urandom_range(3)), $urandom_range(3) == 0, 1'($urandom_range(1)), $urandom);
            set_bus(1, 2'($urandom_range(3)), $urandom_range(3) == 0, 1'($urandom_range(1)), $urandom);
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                #1;
                chk("async_rd_a", bus_a.readdata, 32'h0);
                chk("async_irq_a", bus_a.irq, 1'b0);
                chk("async_rd_b", bus_b.readdata, 32'h0);
                chk("async_irq_b", bus_b.irq, 1'b0);
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        set_bus(0, 2'd0, 1'b0, 1'b1, 32'd0);
        set_bus(1, 2'd0, 1'b0, 1'b1, 32'd0);
        repeat (2) @(negedge clk);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
